// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port word RAM between the instruction-fetch
// port (read-only) and the data port (read/write). The data port wins on
// contention. A starvation counter forces fetch through after STARVE_LIMIT
// consecutive denied cycles. Responses are registered one cycle after grant.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // RAM side
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Arbitration: data first unless fetch has waited LIMIT cycles; nothing
  // is granted while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && (!f_req || (starve_cnt < LIMIT))) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  // RAM drive: granted port's address (fetch address when idle).
  always_comb begin
    ram_addr  = d_gnt ? d_addr : f_addr;
    ram_wdata = d_wdata;
    ram_we    = d_gnt & d_we;
  end

  // Starvation counter: counts denied fetch cycles, saturating at LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (f_req && !f_gnt) begin
      if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Fetch response register: capture RAM data at the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
    end else begin
      f_rvalid <= f_gnt;
      if (f_gnt) begin
        f_rdata <= ram_rdata;
      end
    end
  end

  // Data response register: reads capture RAM data, writes echo wdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_gnt;
      if (d_gnt) begin
        d_rdata <= d_we ? d_wdata : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration rules and memory.
module tb_ram_arbiter;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, ram_we;
  logic [31:0] f_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Bench RAM: 256 words, combinational read, write at clock edge.
  logic [31:0] mem [256];
  logic        mem_clear;
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr[9:2]] <= ram_wdata;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  int          ref_wait;
  logic        exp_frv, exp_drv;
  logic [31:0] exp_frd, exp_drd;
  logic        mdl_fg, mdl_dg;
  logic        obs_fg, obs_dg, obs_we;
  logic [31:0] obs_addr, obs_wd;

  int vectors = 0;
  int miscompares = 0;

  // Fetch may only win contention once it has waited LIM cycles.
  task automatic model_grant(input logic fr, input logic dr);
    mdl_fg = 1'b0;
    mdl_dg = 1'b0;
    if (dr && !(fr && ref_wait >= int'(LIM))) mdl_dg = 1'b1;
    else if (fr) mdl_fg = 1'b1;
  endtask

  task automatic model_edge(input logic fr, input logic [31:0] fa, input logic dwe,
                            input logic [31:0] da, input logic [31:0] dwd);
    if (fr && !mdl_fg) ref_wait = (ref_wait + 1 > int'(LIM)) ? int'(LIM) : ref_wait + 1;
    else ref_wait = 0;
    exp_frv = mdl_fg;
    if (mdl_fg) exp_frd = ref_mem[fa[9:2]];
    exp_drv = mdl_dg;
    if (mdl_dg) begin
      exp_drd = dwe ? dwd : ref_mem[da[9:2]];
      if (dwe) ref_mem[da[9:2]] = dwd;
    end
  endtask

  task automatic model_reset();
    ref_wait = 0;
    exp_frv = 1'b0; exp_drv = 1'b0;
    exp_frd = '0;   exp_drd = '0;
  endtask

  // One cycle: drive at negedge, observe grants, advance model at posedge.
  // Returns 1 time unit after the edge, with responses visible.
  task automatic tick(input logic fr, input logic [31:0] fa, input logic dr,
                      input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    obs_fg = f_gnt; obs_dg = d_gnt; obs_we = ram_we; obs_addr = ram_addr; obs_wd = ram_wdata;
    model_grant(fr, dr);
    @(posedge clk);
    model_edge(fr, fa, dwe, da, dwd);
    #1;
  endtask

  task automatic test_reset();
    mem_clear = 1'b1;
    reset = 1'b1;
    f_req = 1'b1; f_addr = 32'h40; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_reset();
    @(posedge clk); #1;
    mem_clear = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({f_gnt, d_gnt, ram_we} !== 3'b000) begin
      miscompares++; $display("FAIL reset_gnt: got f/d/we=%b required 000", {f_gnt, d_gnt, ram_we});
    end
    vectors++;
    if ({f_rvalid, d_rvalid} !== 2'b00 || f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got rv=%b f_rdata=%h d_rdata=%h required 00/0/0",
               {f_rvalid, d_rvalid}, f_rdata, d_rdata);
    end
    @(negedge clk);
    reset = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_nowrite: got rv=%b rdata=%h required 1/0", f_rvalid, f_rdata);
    end
  endtask

  task automatic test_write_readback();
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h11);
    vectors++;
    if (obs_dg !== 1'b1 || obs_fg !== 1'b0 || obs_we !== 1'b1) begin
      miscompares++; $display("FAIL wr_gnt: got d_gnt=%b f_gnt=%b we=%b required 1/0/1", obs_dg, obs_fg, obs_we);
    end
    vectors++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h11) begin
      miscompares++; $display("FAIL wr_resp: got rv=%b rdata=%h required 1/11", d_rvalid, d_rdata);
    end
    tick(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (obs_fg !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== 32'h11 || d_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_fetch: got gnt=%b rv=%b rdata=%h d_rv=%b required 1/1/11/0",
               obs_fg, f_rvalid, f_rdata, d_rvalid);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (f_rvalid !== 1'b0 || f_rdata !== 32'h11 || d_rdata !== 32'h11) begin
      miscompares++;
      $display("FAIL hold: got f_rv=%b f_rdata=%h d_rdata=%h required 0/11/11", f_rvalid, f_rdata, d_rdata);
    end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'd1; exp_seq[1] = 32'd2; exp_seq[2] = 32'd3;
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), exp_seq[i]);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      vectors++;
      if (obs_fg !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL stream[%0d]: got gnt=%b rv=%b rdata=%h required 1/1/%h",
                 i, obs_fg, f_rvalid, f_rdata, exp_seq[i]);
      end
    end
  endtask

  // Both ports requesting continuously: data wins 4 cycles, then fetch once.
  task automatic test_contention(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
    for (int c = 0; c < 10; c++) begin
      tick(1'b1, addr, 1'b1, 1'b0, addr, 32'h0);
      vectors++;
      if ((c % 5 == 4) ? (obs_fg !== 1'b1 || obs_dg !== 1'b0) : (obs_dg !== 1'b1 || obs_fg !== 1'b0)) begin
        miscompares++;
        $display("FAIL %s[%0d]: got f_gnt=%b d_gnt=%b required %b/%b",
                 tag, c, obs_fg, obs_dg, c % 5 == 4, c % 5 != 4);
      end
      vectors++;
      if ((c % 5 == 4) ? (f_rvalid !== 1'b1 || f_rdata !== exp_data)
                       : (d_rvalid !== 1'b1 || d_rdata !== exp_data)) begin
        miscompares++;
        $display("FAIL %s_data[%0d]: got f=%b/%h d=%b/%h required %h", tag, c,
                 f_rvalid, f_rdata, d_rvalid, d_rdata, exp_data);
      end
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_same_addr();
    tick(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'd5);
    tick(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'd9);
    vectors++;
    if (obs_dg !== 1'b1 || obs_fg !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'd9) begin
      miscompares++;
      $display("FAIL same_wr: got d_gnt=%b f_gnt=%b rv=%b rdata=%h required 1/0/1/9",
               obs_dg, obs_fg, d_rvalid, d_rdata);
    end
    tick(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (obs_fg !== 1'b1 || f_rvalid !== 1'b1 || f_rdata !== 32'd9) begin
      miscompares++;
      $display("FAIL same_rd: got gnt=%b rv=%b rdata=%h required 1/1/9", obs_fg, f_rvalid, f_rdata);
    end
  endtask

  task automatic test_reset_midcycle();
    // Build up two denied fetch cycles, leaving a data response in flight.
    tick(1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'h0);
    tick(1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'h0);
    #2;
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hBAD;
    #1;
    model_reset();
    vectors++;
    if ({f_rvalid, d_rvalid} !== 2'b00 || d_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_resp: got rv=%b d_rdata=%h required 00/0", {f_rvalid, d_rvalid}, d_rdata);
    end
    @(posedge clk); #1;
    vectors++;
    if ({d_gnt, ram_we, d_rvalid} !== 3'b000) begin
      miscompares++; $display("FAIL midrst_gnt: got gnt/we/rv=%b required 000", {d_gnt, ram_we, d_rvalid});
    end
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({f_rvalid, d_rvalid} !== 2'b00) begin
      miscompares++; $display("FAIL midrst_release: got rv=%b required 00", {f_rvalid, d_rvalid});
    end
    // Counter restarted at 0 and the held write never landed (still 0x11).
    test_contention("midrst_cont", 32'h10, 32'h11);
  endtask

  task automatic test_random();
    logic        fr = 1'b0, dr = 1'b0, dwe = 1'b0;
    logic [31:0] fa = '0, da = '0, dwd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!fr || mdl_fg) begin
        fr = ($urandom_range(0, 3) != 0);
        fa = 32'($urandom_range(0, 255)) & 32'h3FF;
      end
      if (!dr || mdl_dg) begin
        dr = ($urandom_range(0, 3) != 0);
        dwe = $urandom_range(0, 1) == 1;
        da = 32'($urandom_range(0, 255)) & 32'h3FF;
        dwd = $urandom;
      end
      tick(fr, fa, dr, dwe, da, dwd);
      vectors++;
      if (obs_fg !== mdl_fg || obs_dg !== mdl_dg || obs_we !== (mdl_dg & dwe)) begin
        miscompares++;
        $display("FAIL rnd_gnt[%0d]: got f/d/we=%b%b%b required %b%b%b",
                 n, obs_fg, obs_dg, obs_we, mdl_fg, mdl_dg, mdl_dg & dwe);
      end
      vectors++;
      if ((mdl_dg && (obs_addr !== da || obs_wd !== dwd)) || (mdl_fg && obs_addr !== fa)) begin
        miscompares++;
        $display("FAIL rnd_addr[%0d]: got addr=%h wd=%h required f=%h d=%h wd=%h",
                 n, obs_addr, obs_wd, fa, da, dwd);
      end
      vectors++;
      if (f_rvalid !== exp_frv || f_rdata !== exp_frd || d_rvalid !== exp_drv || d_rdata !== exp_drd) begin
        miscompares++;
        $display("FAIL rnd_resp[%0d]: got f=%b/%h d=%b/%h required f=%b/%h d=%b/%h", n,
                 f_rvalid, f_rdata, d_rvalid, d_rdata, exp_frv, exp_frd, exp_drv, exp_drd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_fetch_stream();
    test_contention("contention", 32'h4, 32'd2);
    test_same_addr();
    test_reset_midcycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port word RAM between the instruction-fetch stage (read-only) and the memory stage (read/write).
- Grants at most one access per cycle and returns registered responses one cycle after the grant.
- Data port has priority; a starvation counter guarantees fetch progress.
- Sits between the pipeline's IF/MEM stages and the ram instance.

Parameters:
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch is forced to win. Legal range is 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- f_req  in  1  fetch read request
- f_addr  in  $bits(RamAddress)  fetch byte address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  32 (Word)  fetch read data
- d_req  in  1  data-port request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  $bits(RamAddress)  data byte address
- d_wdata  in  32 (Word)  write data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  data response valid, for reads and writes
- d_rdata  out  32 (Word)  data read result
- ram_we  out  1  to ram write_enable
- ram_addr  out  $bits(RamAddress)  to ram address
- ram_wdata  out  32  to ram in
- ram_rdata  in  32  from ram out (combinational read)

Behaviour:
- Reset (async, immediate):
  - f_rvalid, d_rvalid, f_rdata, d_rdata, and the starvation counter go to 0.
  - While reset is high, f_gnt, d_gnt, and ram_we are forced to 0.
- Handshake:
  - The requester holds req, addr, we, and wdata stable until it sees gnt high in the same cycle.
  - gnt is combinational from req and the counter.
  - A transfer occurs at the rising edge where gnt=1.
- Arbitration (combinational, per cycle):
  - Only f_req: f_gnt=1.
  - Only d_req: d_gnt=1.
  - Both, with counter < STARVE_LIMIT: d_gnt=1.
  - Both, with counter >= STARVE_LIMIT: f_gnt=1.
  - f_gnt and d_gnt are never both 1.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each edge where f_req=1 and f_gnt=0.
  - Clears on any edge where f_gnt=1 or f_req=0.
- RAM drive:
  - ram_addr = granted port's address. With no grant it is f_addr (don't care).
  - ram_wdata = d_wdata.
  - ram_we = d_gnt & d_we.
- Response latency: exactly 1 cycle.
  - At the grant edge, ram_rdata is captured into the granted port's rdata register, and that port's rvalid is set for the next cycle.
  - For a data write: d_rdata captures d_wdata (write-through echo), and d_rvalid pulses.
- rvalid:
  - Each rvalid is high for exactly one cycle per grant.
  - Back-to-back grants to one port give continuous rvalid with new data each cycle.
- rdata registers hold their value when rvalid=0.
- Read-after-write: a read of the same address on the cycle following a write returns the new value, because the RAM write lands at the grant edge.
- Alignment: addresses are passed through unmodified. Word selection is the RAM's responsibility.
- Reset mid-operation: any response pending from the last grant is dropped, with no rvalid after reset deasserts. A write whose grant edge has not occurred is not performed.
- No internal FSM beyond the counter and response registers. Throughput is 1 access/cycle total.

Test Plan:
- Reset, then write 0x11 at addr 0x10 via the data port.
  - Required: d_gnt=1 on the request cycle.
  - Required: next cycle d_rvalid=1, d_rdata=0x11.
  - Required: a fetch of 0x10 then returns f_rdata=0x11 one cycle after f_gnt.
- Fetch-only stream of addresses 0x0, 0x4, 0x8 (preloaded 1, 2, 3) on consecutive cycles.
  - Required: f_gnt=1 every cycle.
  - Required: f_rvalid continuous for 3 cycles with f_rdata 1, 2, 3.
- Contention with STARVE_LIMIT=4: f_req and d_req (reads) held high for 10 cycles.
  - Required: d_gnt for cycles 0–3, f_gnt on cycle 4, counter back to 0.
  - Required: d_gnt for cycles 5–8, f_gnt on cycle 9.
  - Required: f_gnt and d_gnt never both set.
- Simultaneous write and fetch to the same address 0x20 (old value 5, write 9).
  - Required: the write wins, with d_rvalid next cycle.
  - Required: the fetch is granted the following cycle and returns 9.
- Assert reset asynchronously mid-cycle, after a grant edge and before the response cycle ends.
  - Required: f_rvalid/d_rvalid drop to 0 immediately, with no rvalid after release.
  - Required: the counter is 0, and a held d_we write is not performed while reset is high.
